serial_cmd_master: RTL and testbench

- Host-side initiator for the board's byte-serial command protocol; drives a UART transmitter and monitors a UART receiver.
- Accepts one command request: opcode byte, 0-2 argument bytes, and the expected response byte count.
- Transmits the command bytes in order, then collects the response bytes and emits them one per pulse.
- Ends each transaction with done, or with timeout_err if the responder stalls; lets a control FPGA script firmware-version reads, threshold writes, histogram dumps and PLL phase steps on a trigger board.

---
 rtl/serial_cmd_master.sv | 127 ++++++++++++
 tb/tb_serial_cmd_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_master.sv
// Host-side initiator for the byte-serial command protocol: sends opcode plus
// up to two argument bytes over a UART, then collects a fixed-length response.
module serial_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RESP       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_opcode,
    input  logic [1:0] cmd_nargs,
    input  logic [7:0] cmd_arg0,
    input  logic [7:0] cmd_arg1,
    input  logic [5:0] cmd_nresp,
    input  logic       txBusy,
    output logic       txStart,
    output logic [7:0] txData,
    input  logic       rxReady,
    input  logic [7:0] rxData,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    output logic [5:0] resp_index,
    output logic       resp_last,
    output logic       done,
    output logic       timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, RECV, FIN} state_t;

    state_t        state;
    logic [7:0]    op, a0, a1;
    logic [1:0]    nargs, ptr;
    logic [5:0]    nresp, rcnt;
    logic [TW-1:0] tcnt;
    logic [1:0]    nargs_c;
    logic [5:0]    nresp_c;

    assign nargs_c   = (cmd_nargs == 2'd3) ? 2'd2 : cmd_nargs;
    assign nresp_c   = (cmd_nresp > 6'(MAX_RESP)) ? 6'(MAX_RESP) : cmd_nresp;
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op          <= '0;
            a0          <= '0;
            a1          <= '0;
            nargs       <= '0;
            nresp       <= '0;
            ptr         <= '0;
            rcnt        <= '0;
            tcnt        <= '0;
            txStart     <= 1'b0;
            txData      <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_index  <= '0;
            resp_last   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            txStart    <= 1'b0;
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    op          <= cmd_opcode;
                    a0          <= cmd_arg0;
                    a1          <= cmd_arg1;
                    nargs       <= nargs_c;
                    nresp       <= nresp_c;
                    ptr         <= '0;
                    timeout_err <= 1'b0;
                    state       <= LOAD;
                end
                LOAD: begin
                    txData <= (ptr == 2'd0) ? op : (ptr == 2'd1) ? a0 : a1;
                    state  <= SEND;
                end
                SEND: if (!txBusy) begin
                    txStart <= 1'b1;
                    state   <= GAP;
                end
                // txBusy may lag txStart by a cycle, so it is not looked at here
                GAP: begin
                    if (ptr < nargs) begin
                        ptr   <= ptr + 2'd1;
                        state <= LOAD;
                    end else if (nresp == 6'd0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt  <= '0;
                        rcnt  <= '0;
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (rxReady) begin
                        resp_valid <= 1'b1;
                        resp_data  <= rxData;
                        resp_index <= rcnt;
                        resp_last  <= (rcnt == nresp - 6'd1);
                        rcnt       <= rcnt + 6'd1;
                        tcnt       <= '0;
                        if (rcnt + 6'd1 == nresp) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= FIN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                // done is high for exactly the cycle spent here
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cmd_master.sv
// Directed bench for serial_cmd_master: drives a small UART transmitter model
// and hand-fed responder bytes, checking pulses against hand-computed values.
module tb_serial_cmd_master;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_opcode = '0, cmd_arg0 = '0, cmd_arg1 = '0;
    logic [1:0] cmd_nargs = '0;
    logic [5:0] cmd_nresp = '0;
    logic       txBusy, txStart;
    logic [7:0] txData;
    logic       rxReady = 1'b0;
    logic [7:0] rxData = '0;
    logic       resp_valid, resp_last, done, timeout_err;
    logic [7:0] resp_data;
    logic [5:0] resp_index;

    serial_cmd_master #(.TIMEOUT_CYCLES(50), .MAX_RESP(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_nargs(cmd_nargs), .cmd_arg0(cmd_arg0),
        .cmd_arg1(cmd_arg1), .cmd_nresp(cmd_nresp), .txBusy(txBusy),
        .txStart(txStart), .txData(txData), .rxReady(rxReady), .rxData(rxData),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_index(resp_index),
        .resp_last(resp_last), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for 4 cycles after each launch, plus a forced hold.
    int   busy_cnt = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (txStart) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign txBusy = (busy_cnt != 0) || force_busy;

    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    logic [7:0] rd_q[$];
    logic [5:0] ri_q[$];
    logic       rl_q[$];
    int         r_cyc[$];
    int         done_n = 0;
    int         done_cyc = 0;
    always @(negedge clk) begin
        if (txStart) begin tx_q.push_back(txData); tx_cyc.push_back(cyc); end
        if (resp_valid) begin
            rd_q.push_back(resp_data); ri_q.push_back(resp_index);
            rl_q.push_back(resp_last); r_cyc.push_back(cyc);
        end
        if (done) begin done_n = done_n + 1; done_cyc = cyc; end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [1:0] na, input logic [7:0] x0,
                            input logic [7:0] x1, input logic [5:0] nr);
        int k = 0;
        while (!cmd_ready && k < 200) begin tick(); k++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_opcode = op; cmd_nargs = na; cmd_arg0 = x0; cmd_arg1 = x1; cmd_nresp = nr;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("accepted", cmd_ready, 0);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 500) begin tick(); k++; end
        chk("tx_wait", tx_q.size() >= n, 1);
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_n < n && k < 500) begin tick(); k++; end
        chk("done_wait", done_n >= n, 1);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rxReady = 1'b1; rxData = b;
        tick();
        rxReady = 1'b0;
        tick();
    endtask

    int tb_, rb, db, c0;

    initial begin
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_txStart", txStart, 0);
        chk("rst_txData", txData, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_index", resp_index, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        tick();

        // 1: firmware-version read
        tb_ = tx_q.size(); rb = rd_q.size(); db = done_n;
        send_cmd(8'h00, 2'd0, 8'h00, 8'h00, 6'd1);
        wait_tx(tb_ + 1);
        repeat (2) tick();
        rx_byte(8'h03);
        wait_done(db + 1);
        repeat (4) tick();
        chk("t1_tx_count", tx_q.size() - tb_, 1);
        chk("t1_tx_data", tx_q[tb_], 8'h00);
        chk("t1_resp_count", rd_q.size() - rb, 1);
        chk("t1_resp_data", rd_q[rb], 8'h03);
        chk("t1_resp_index", ri_q[rb], 0);
        chk("t1_resp_last", rl_q[rb], 1);
        chk("t1_done_count", done_n - db, 1);
        chk("t1_timeout_err", timeout_err, 0);

        // 2: write with one argument, stray rxReady while sending
        tb_ = tx_q.size(); rb = rd_q.size(); db = done_n;
        send_cmd(8'h01, 2'd1, 8'h0A, 8'h00, 6'd0);
        tick();
        rx_byte(8'hEE);
        wait_done(db + 1);
        repeat (4) tick();
        chk("t2_tx_count", tx_q.size() - tb_, 2);
        chk("t2_tx_data0", tx_q[tb_], 8'h01);
        chk("t2_tx_data1", tx_q[tb_ + 1], 8'h0A);
        chk("t2_resp_count", rd_q.size() - rb, 0);
        chk("t2_done_count", done_n - db, 1);

        // 3: histogram dump, 32 bytes
        tb_ = tx_q.size(); rb = rd_q.size(); db = done_n;
        send_cmd(8'h0A, 2'd0, 8'h00, 8'h00, 6'd32);
        wait_tx(tb_ + 1);
        repeat (2) tick();
        for (int i = 0; i < 32; i++) rx_byte(8'(i));
        wait_done(db + 1);
        rx_byte(8'h77);
        repeat (4) tick();
        chk("t3_tx_data", tx_q[tb_], 8'h0A);
        chk("t3_resp_count", rd_q.size() - rb, 32);
        for (int i = 0; i < 32; i++) begin
            chk("t3_index", ri_q[rb + i], 32'(rd_q[rb + i]));
            chk("t3_last", rl_q[rb + i], (i == 31) ? 1 : 0);
        end
        chk("t3_done_count", done_n - db, 1);

        // 4: timeout after one of two bytes
        tb_ = tx_q.size(); rb = rd_q.size(); db = done_n;
        send_cmd(8'h10, 2'd0, 8'h00, 8'h00, 6'd2);
        wait_tx(tb_ + 1);
        repeat (2) tick();
        rx_byte(8'h5A);
        wait_done(db + 1);
        repeat (2) tick();
        chk("t4_resp_count", rd_q.size() - rb, 1);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_done_delay", done_cyc - r_cyc[rb], 50);
        db = done_n;
        send_cmd(8'h00, 2'd0, 8'h00, 8'h00, 6'd0);
        chk("t4_err_cleared", timeout_err, 0);
        wait_done(db + 1);

        // 5: backpressure on the argument byte
        tb_ = tx_q.size(); db = done_n;
        send_cmd(8'h02, 2'd1, 8'h55, 8'h00, 6'd0);
        wait_tx(tb_ + 1);
        force_busy = 1'b1;
        repeat (100) tick();
        chk("t5_held", tx_q.size() - tb_, 1);
        c0 = cyc;
        force_busy = 1'b0;
        wait_done(db + 1);
        repeat (2) tick();
        chk("t5_tx_count", tx_q.size() - tb_, 2);
        chk("t5_arg_data", tx_q[tb_ + 1], 8'h55);
        chk("t5_arg_cycle", tx_cyc[tb_ + 1], c0 + 1);

        // 7: nargs=3 behaves as 2
        tb_ = tx_q.size(); db = done_n;
        send_cmd(8'h05, 2'd3, 8'h11, 8'h22, 6'd0);
        wait_done(db + 1);
        repeat (2) tick();
        chk("t7_tx_count", tx_q.size() - tb_, 3);
        chk("t7_arg1", tx_q[tb_ + 2], 8'h22);

        // 6: reset after 10 of 32 bytes
        tb_ = tx_q.size(); db = done_n;
        send_cmd(8'h0A, 2'd0, 8'h00, 8'h00, 6'd32);
        wait_tx(tb_ + 1);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) rx_byte(8'(i));
        reset = 1'b1;
        #1;
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_resp_index", resp_index, 0);
        chk("t6_txData", txData, 0);
        chk("t6_timeout_err", timeout_err, 0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t6_no_done", done_n - db, 0);
        chk("t6_no_tx", tx_q.size() - tb_, 1);
        rb = rd_q.size();
        send_cmd(8'h00, 2'd0, 8'h00, 8'h00, 6'd1);
        wait_tx(tb_ + 2);
        repeat (2) tick();
        rx_byte(8'h03);
        wait_done(db + 1);
        chk("t6_resp_data", rd_q[rb], 8'h03);
        chk("t6_resp_last", rl_q[rb], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
